// File: rtl/typedef_pkg.sv
// Shared types for the parametrised ALU: opcode encoding and controller states.
package typedef_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        MUL = 3'd1,
        OR  = 3'd2,
        AND = 3'd3,
        SUB = 3'd4,
        XOR = 3'd5
    } operation_t;

    localparam int unsigned OP_COUNT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2
    } alu_state_t;

endpackage

// File: rtl/param_alu_mult.sv
// Shift-add multiplier, one multiplier bit per cycle, LSB first.
// done/product are combinational on the final step so the caller can register them.
module seq_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;
    logic [2*WIDTH-1:0] acc_d;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Last step: the counter reaches WIDTH on this edge.
    assign done    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand};
            mplier_q <= mplier;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_alu.sv
// Parametrised ALU: single-cycle ADD/SUB/OR/AND/XOR, multi-cycle MUL, illegal-opcode flag.
// Optional zero/carry status outputs are enabled by defining ALU_STATUS_FLAGS_EN.
module param_alu
    import typedef_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_start,
    input  logic [2:0]         operation,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
`ifdef ALU_STATUS_FLAGS_EN
    output logic               zero,
    output logic               carry,
`endif
    output logic               op_err
);

    alu_state_t         state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] exec_res;
    logic               exec_err;
    logic               mult_start;
    logic               mult_done;
    logic [2*WIDTH-1:0] mult_product;

    assign mult_start = op_start && (state_q == IDLE) && (operation == MUL);

    seq_mult #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .mcand   (operand_a),
        .mplier  (operand_b),
        .done    (mult_done),
        .product (mult_product)
    );

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        case (op_q)
            ADD:        exec_res[WIDTH:0]   = {1'b0, a_q} + {1'b0, b_q};
            SUB:        exec_res[WIDTH:0]   = {1'b0, a_q} - {1'b0, b_q};
            OR:         exec_res[WIDTH-1:0] = a_q | b_q;
            AND:        exec_res[WIDTH-1:0] = a_q & b_q;
            XOR:        exec_res[WIDTH-1:0] = a_q ^ b_q;
            3'd6, 3'd7: exec_err            = 1'b1;
            default:    exec_res            = '0;
        endcase
    end

`ifdef ALU_STATUS_FLAGS_EN
    logic zero_q;
    logic carry_q;
    assign zero  = zero_q;
    assign carry = carry_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
`ifdef ALU_STATUS_FLAGS_EN
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (op_start) begin
                        op_q    <= operation;
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        busy_q  <= 1'b1;
                        state_q <= (operation == MUL) ? MULT : EXEC;
                    end
                end
                EXEC: begin
                    result_q <= exec_res;
                    done_q   <= 1'b1;
                    err_q    <= exec_err;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
`ifdef ALU_STATUS_FLAGS_EN
                    zero_q   <= (exec_res == '0);
                    carry_q  <= ((op_q == ADD) || (op_q == SUB)) && exec_res[WIDTH];
`endif
                end
                MULT: begin
                    if (mult_done) begin
                        result_q <= mult_product;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
`ifdef ALU_STATUS_FLAGS_EN
                        zero_q   <= (mult_product == '0);
                        carry_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign op_err = err_q;

endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu: directed WIDTH=8 scenarios plus a randomized WIDTH=16 run.
module tb_param_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, err8;
    logic [15:0] res8;

    logic        s16 = 1'b0;
    logic [2:0]  op16 = 3'd0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, err16;
    logic [31:0] res16;

`ifdef ALU_STATUS_FLAGS_EN
    logic zero8, carry8, zero16, carry16;
`endif

    int checks = 0;
    int errors = 0;

    param_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .op_start(s8), .operation(op8),
        .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8), .result(res8),
`ifdef ALU_STATUS_FLAGS_EN
        .zero(zero8), .carry(carry8),
`endif
        .op_err(err8)
    );

    param_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .op_start(s16), .operation(op16),
        .operand_a(a16), .operand_b(b16), .busy(busy16), .done(done16), .result(res16),
`ifdef ALU_STATUS_FLAGS_EN
        .zero(zero16), .carry(carry16),
`endif
        .op_err(err16)
    );

    // Reference: result of an op on w-bit unsigned operands, straight from the arithmetic rules.
    function automatic longint unsigned ref_result(int op, longint unsigned a,
                                                   longint unsigned b, int w);
        longint unsigned mask;
        mask = (64'd1 << (w + 1)) - 1;
        case (op)
            0: return a + b;
            1: return a * b;
            2: return a | b;
            3: return a & b;
            4: return (a - b) & mask;
            5: return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then scramble operands to prove they were latched.
    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        s8 = 1'b1; op8 = op; a8 = a; b8 = b;
        tick();
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s8 = 1'b1; op8 = 3'd0; a8 = 8'd1; b8 = 8'd1;
        tick();
        tick();
        s8 = 1'b0;
        rst = 1'b0;
        checks++;
        if ({busy8, done8, err8, res8} !== 19'd0) begin
            errors++; $display("FAIL reset8 got %h want 0", {busy8, done8, err8, res8});
        end
        checks++;
        if ({busy16, done16, err16, res16} !== 35'd0) begin
            errors++; $display("FAIL reset16 got %h want 0", {busy16, done16, err16, res16});
        end
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored busy=%b want 0", busy8);
        end
    endtask

    task automatic test_add_carry();
        issue8(3'd0, 8'd255, 8'd1);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++; $display("FAIL add_accept busy=%b done=%b want 1 0", busy8, done8);
        end
        tick();
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || err8 !== 1'b0 || res8 !== 16'h0100) begin
            errors++;
            $display("FAIL add_result done=%b busy=%b err=%b res=%h want 1 0 0 0100",
                     done8, busy8, err8, res8);
        end
`ifdef ALU_STATUS_FLAGS_EN
        checks++;
        if (carry8 !== 1'b1 || zero8 !== 1'b0) begin
            errors++; $display("FAIL add_flags carry=%b zero=%b want 1 0", carry8, zero8);
        end
`endif
        tick();
        checks++;
        if (done8 !== 1'b0 || res8 !== 16'h0100) begin
            errors++; $display("FAIL add_hold done=%b res=%h want 0 0100", done8, res8);
        end
    endtask

    task automatic test_mul_busy_ignore();
        int done_at;
        done_at = -1;
        issue8(3'd1, 8'd255, 8'd255);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                s8 = 1'b1; op8 = 3'd0; a8 = 8'd1; b8 = 8'd1;
            end
            tick();
            s8 = 1'b0;
            if (done8 === 1'b1 && done_at < 0) done_at = k;
            if (k < 8 && busy8 !== 1'b1) begin
                checks++; errors++; $display("FAIL mul_busy cycle %0d busy=%b want 1", k, busy8);
            end
        end
        checks++;
        if (done_at != 8 || res8 !== 16'hFE01 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL mul_result done_at=%0d res=%h busy=%b want 8 FE01 0",
                     done_at, res8, busy8);
        end
        tick();
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'hFE01) begin
            errors++;
            $display("FAIL mul_ignored_start busy=%b done=%b res=%h want 0 0 FE01",
                     busy8, done8, res8);
        end
    endtask

    task automatic test_back_to_back();
        issue8(3'd4, 8'd3, 8'd5);
        tick();
        checks++;
        if (done8 !== 1'b1 || res8 !== 16'h01FE) begin
            errors++; $display("FAIL sub_result done=%b res=%h want 1 01FE", done8, res8);
        end
`ifdef ALU_STATUS_FLAGS_EN
        checks++;
        if (carry8 !== 1'b1 || zero8 !== 1'b0) begin
            errors++; $display("FAIL sub_flags carry=%b zero=%b want 1 0", carry8, zero8);
        end
`endif
        issue8(3'd5, 8'hF0, 8'h3C);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++; $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy8, done8);
        end
        tick();
        checks++;
        if (done8 !== 1'b1 || res8 !== 16'h00CC) begin
            errors++; $display("FAIL xor_result done=%b res=%h want 1 00CC", done8, res8);
        end
    endtask

    task automatic test_illegal();
        issue8(3'd7, 8'h55, 8'hAA);
        tick();
        checks++;
        if (done8 !== 1'b1 || err8 !== 1'b1 || res8 !== 16'h0000 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL illegal done=%b err=%b res=%h busy=%b want 1 1 0000 0",
                     done8, err8, res8, busy8);
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || err8 !== 1'b0) begin
            errors++; $display("FAIL illegal_clear done=%b err=%b want 0 0", done8, err8);
        end
    endtask

    task automatic test_mul_reset();
        int seen_done;
        int done_at;
        seen_done = 0;
        done_at = -1;
        issue8(3'd1, 8'd200, 8'd100);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || res8 !== 16'h0000 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL mul_abort busy=%b res=%h done=%b want 0 0000 0", busy8, res8, done8);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done8 === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++; $display("FAIL mul_abort_no_done pulses=%0d want 0", seen_done);
        end
        issue8(3'd1, 8'd2, 8'd3);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (done8 === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (done_at != 8 || res8 !== 16'd6) begin
            errors++; $display("FAIL mul_after_reset done_at=%0d res=%h want 8 0006", done_at, res8);
        end
    endtask

    task automatic test_random16();
        int op;
        int lat;
        int want_lat;
        longint unsigned a, b, exp;
        for (int n = 0; n < 10000; n++) begin
            if (n == 0) begin
                op = 1; a = 64'hFFFF; b = 64'hFFFF;
            end else if (n == 1) begin
                op = 0; a = 64'hFFFF; b = 64'h0001;
            end else begin
                op = $urandom_range(0, 15);
                op = (op < 14) ? (op % 6) : (6 + op % 2);
                a = 64'($urandom_range(0, 65535));
                b = 64'($urandom_range(0, 65535));
            end
            exp = ref_result(op, a, b, 16);
            want_lat = (op == 1) ? 16 : 1;
            s16 = 1'b1; op16 = 3'(op); a16 = 16'(a); b16 = 16'(b);
            tick();
            lat = 0;
            // Ignored requests with junk operands while the op is in flight.
            while (lat < 40) begin
                s16 = 1'($urandom_range(0, 1));
                op16 = 3'($urandom);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                tick();
                lat++;
                if (done16 === 1'b1) break;
            end
            s16 = 1'b0;
            checks++;
            if (lat != want_lat) begin
                errors++; $display("FAIL rnd_latency op=%0d got %0d want %0d", op, lat, want_lat);
            end
            checks++;
            if (res16 !== 32'(exp) || err16 !== (op > 5)) begin
                errors++;
                $display("FAIL rnd_result op=%0d a=%h b=%h got %h err=%b want %h err=%b",
                         op, a, b, res16, err16, 32'(exp), (op > 5));
            end
`ifdef ALU_STATUS_FLAGS_EN
            checks++;
            if (zero16 !== (exp == 0) ||
                carry16 !== ((op == 0 || op == 4) ? exp[16] : 1'b0)) begin
                errors++;
                $display("FAIL rnd_flags op=%0d zero=%b carry=%b exp=%h", op, zero16, carry16, exp);
            end
`endif
            if (lat >= 40) break;
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_mul_busy_ignore();
        test_back_to_back();
        test_illegal();
        test_mul_reset();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
